// File: rtl/fibonacci_pkg.sv
// Shared types for the Fibonacci term generator.
//   state_t : 2-bit FSM state encoding (IDLE, EMIT, WAIT, DONE)
package fibonacci_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage : fibonacci_pkg

// File: rtl/fibonacci_term_generator.sv
// Emits F0, F1, F2, ... as single-cycle new_fib_res pulses spaced GAP idle
// cycles apart, stopping on the term count, an abort, or term overflow.
//   clk, arst_n  : rising-edge clock, asynchronous active-low reset
//   start        : begin a run (sampled in IDLE only), n_terms latched here
//   abort        : cancel a run; returns to IDLE without a done pulse
//   n_terms      : number of terms requested
//   fib_out      : current term, valid with new_fib_res, held otherwise
//   new_fib_res  : one-cycle pulse per emitted term
//   term_idx     : index k of the term on fib_out
//   busy         : high whenever not IDLE
//   done         : one-cycle pulse when a run completes or overflows
//   overflow     : sticky flag, run ended because the next term did not fit
module fibonacci_term_generator
  import fibonacci_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned GAP         = 1
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [COUNT_WIDTH-1:0] n_terms,
  output logic [DATA_WIDTH-1:0]  fib_out,
  output logic                   new_fib_res,
  output logic [COUNT_WIDTH-1:0] term_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  // Gap counter runs GAP-1 down to 0, so it only needs to hold GAP-1.
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0]       GAP_LOAD = GAP_W'(GAP - 1);
  localparam logic [GAP_W-1:0]       GAP_ONE  = GAP_W'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic                   a_ovf_q, a_ovf_d, b_ovf_q, b_ovf_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [COUNT_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0]  fib_q, fib_d;
  logic                   nfr_q, nfr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ovf_q, ovf_d;
  logic [DATA_WIDTH:0]    sum_c;

  // Next term with carry-out; the carry marks a term that no longer fits.
  assign sum_c = {1'b0, a_q} + {1'b0, b_q};

  // Next-state and datapath update; outputs are decoded from the next state
  // so they register in step with the state they describe.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    a_ovf_d = a_ovf_q;
    b_ovf_d = b_ovf_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          ovf_d = 1'b0;
          if (n_terms != '0) begin
            a_d     = '0;
            b_d     = DATA_WIDTH'(1);
            a_ovf_d = 1'b0;
            b_ovf_d = 1'b0;
            idx_d   = '0;
            rem_d   = n_terms;
            state_d = ST_EMIT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_EMIT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_d = ST_DONE;
          end else begin
            a_d     = b_q;
            a_ovf_d = b_ovf_q;
            b_d     = sum_c[DATA_WIDTH-1:0];
            b_ovf_d = b_ovf_q | sum_c[DATA_WIDTH];
            gap_d   = GAP_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (gap_q != '0) begin
          gap_d = gap_q - GAP_ONE;
        end else if (a_ovf_q) begin
          // The out-of-range term is dropped rather than emitted truncated.
          ovf_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + CNT_ONE;
          state_d = ST_EMIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    nfr_d  = (state_d == ST_EMIT);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    fib_d  = (state_d == ST_EMIT) ? a_d : fib_q;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      a_ovf_q <= 1'b0;
      b_ovf_q <= 1'b0;
      rem_q   <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      fib_q   <= '0;
      nfr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      a_ovf_q <= a_ovf_d;
      b_ovf_q <= b_ovf_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      fib_q   <= fib_d;
      nfr_q   <= nfr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign fib_out     = fib_q;
  assign new_fib_res = nfr_q;
  assign term_idx    = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overflow    = ovf_q;

endmodule : fibonacci_term_generator
